cam_cmd_issuer: RTL and testbench
=================================

Name: cam_cmd_issuer

Overview:
- Host-side transmitter for the CAM command stream. Converts one high-level request (opcode, count, payload stream) into the 512-bit beat sequence that the CAM kernel command FSM consumes.
- Waits for the kernel's completion strobe before it accepts the next request, so the kernel's command FSM only ever sees beats while it is in IDLE or actively consuming payload.
- Sits between the host request logic and the CAM kernel's data_in/data_in_valid input.

Parameters:
- C_DATA_WIDTH, 512, width of command and payload beats.
- OP_CODE_WIDTH, 3, width of the request opcode.
- TIMEOUT_CYCLES, 65535, completion watchdog limit. Used only with CAM_CMD_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid&req_ready.
- req_op  in  OP_CODE_WIDTH  1=UPDATE_ALL, 2=SEARCH, 3=UPDATE_ONE.
- req_count  in  30  payload beats for UPDATE_ALL. Ignored for other opcodes.
- pay_data  in  C_DATA_WIDTH  payload beat (entries or key).
- pay_valid  in  1  payload beat present.
- pay_ready  out  1  payload beat consumed.
- cmd_data  out  C_DATA_WIDTH  beat to CAM kernel.
- cmd_valid  out  1  beat valid.
- cmd_ready  in  1  kernel-side accept.
- search_end  in  1  kernel completion for SEARCH/UPDATE_ONE.
- update_all_end  in  1  kernel completion for UPDATE_ALL.
- busy  out  1  request in flight.
- done  out  1  one-cycle pulse on completion.
- err_illegal  out  1  one-cycle pulse when an illegal opcode is rejected.
- timeout  out  1  one-cycle pulse when the watchdog fires.
- cmd_done_cnt  out  32  completed-command counter.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE; req_ready=1; cmd_valid=0; cmd_data=0; pay_ready=0; busy=0; done=0; err_illegal=0; timeout=0; cmd_done_cnt=0; beats_left=0; end_seen=0. Reset mid-operation abandons the transfer; cmd_valid is 0 in the cycle after rst.
- States: IDLE, SEND_CMD, SEND_PAY, WAIT_END.
- IDLE:
  - req_ready=1.
  - On handshake with a legal op: latch op; beats_left = req_count for UPDATE_ALL, 1 for SEARCH and UPDATE_ONE; go to SEND_CMD.
  - On handshake with an illegal op (0, 4-7): pulse err_illegal next cycle, emit nothing, stay in IDLE.
- SEND_CMD:
  - Registered command beat. cmd_data[31:0]=op zero-extended; cmd_data[61:32]=req_count for UPDATE_ALL, otherwise 0; all other bits 0.
  - cmd_valid=1 and cmd_data are held stable until cmd_ready.
  - On the accept cycle: go to SEND_PAY if beats_left!=0, else WAIT_END.
- SEND_PAY:
  - Zero-latency pass-through: cmd_data=pay_data, cmd_valid=pay_valid, pay_ready=cmd_ready.
  - beats_left decrements on each pay_valid&cmd_ready.
  - On the last beat's accept, go to WAIT_END.
  - pay_ready=0 in every other state.
- WAIT_END:
  - Exits on update_all_end (UPDATE_ALL) or search_end (SEARCH, UPDATE_ONE). The strobe for the other op class is ignored.
  - On exit: done pulses one cycle, cmd_done_cnt increments (wraps 0xFFFFFFFF->0), return to IDLE.
  - The next request is accepted earliest in the cycle after done.
- Early completion: a matching end strobe seen in SEND_CMD or SEND_PAY sets sticky end_seen. WAIT_END with end_seen=1 exits in its first cycle and clears end_seen.
- Simultaneous events: if end strobe and last payload accept occur in the same cycle, set end_seen; complete in the first WAIT_END cycle.
- busy=1 in every state except IDLE.
- beats_left is 30-bit; the maximum count 2^30-1 is legal.

Optional Feature:
- Macro: CAM_CMD_TIMEOUT_EN.
- Defined: a 32-bit counter clears on entry to WAIT_END and increments each WAIT_END cycle. When it reaches TIMEOUT_CYCLES: timeout pulses one cycle, return to IDLE, done does not pulse, cmd_done_cnt unchanged, end_seen cleared. A completion strobe in the same cycle as the limit takes priority and gives a normal done.
- Undefined: WAIT_END waits indefinitely; timeout is tied to 0; no counter is synthesized.

Test Plan:
- SEARCH: req_op=2; cmd_ready=1. -> Beat0 [31:0]=2 and [61:32]=0, then one payload beat. search_end 5 cycles later -> done pulse, cmd_done_cnt=1.
- UPDATE_ALL: req_count=4; cmd_ready toggling 1/0. -> Beat0 [61:32]=4, then exactly 4 payload beats, data stable while stalled. update_all_end -> done. An earlier search_end is ignored.
- UPDATE_ALL with req_count=0 -> command beat only, direct to WAIT_END. update_all_end -> done.
- req_op=5 -> err_illegal pulse, cmd_valid stays 0, req_ready stays 1.
- UPDATE_ONE with search_end asserted on the payload accept cycle -> done in the first WAIT_END cycle. rst asserted during SEND_PAY of a later UPDATE_ALL -> cmd_valid=0 and busy=0 next cycle.
- With CAM_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: SEARCH with no search_end -> timeout pulse 16 cycles into WAIT_END, no done, then a new request is accepted.

Source files
------------

// File: rtl/cam_cmd_issuer.sv
// CAM command stream transmitter: one request -> command beat, payload beats, wait for completion.
// Optional completion watchdog enabled by defining CAM_CMD_TIMEOUT_EN.
module cam_cmd_issuer #(
   parameter int C_DATA_WIDTH   = 512,
   parameter int OP_CODE_WIDTH  = 3,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [OP_CODE_WIDTH-1:0] req_op,
   input  logic [29:0]              req_count,
   input  logic [C_DATA_WIDTH-1:0]  pay_data,
   input  logic                     pay_valid,
   output logic                     pay_ready,
   output logic [C_DATA_WIDTH-1:0]  cmd_data,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   input  logic                     search_end,
   input  logic                     update_all_end,
   output logic                     busy,
   output logic                     done,
   output logic                     err_illegal,
   output logic                     timeout,
   output logic [31:0]              cmd_done_cnt,
   output logic [1:0]               state_dbg
);

   // Handshakes: a beat or request transfers on the rising edge where valid and ready are both high.
   localparam logic [OP_CODE_WIDTH-1:0] OP_UPDATE_ALL = OP_CODE_WIDTH'(1);
   localparam logic [OP_CODE_WIDTH-1:0] OP_SEARCH     = OP_CODE_WIDTH'(2);
   localparam logic [OP_CODE_WIDTH-1:0] OP_UPDATE_ONE = OP_CODE_WIDTH'(3);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND_CMD = 2'd1,
      SEND_PAY = 2'd2,
      WAIT_END = 2'd3
   } state_t;

   state_t                    state, state_nxt;
   logic [OP_CODE_WIDTH-1:0]  op_q;
   logic [29:0]               beats_left;
   logic                      end_seen;
   logic [C_DATA_WIDTH-1:0]   cmd_beat, cmd_beat_nxt;
   logic                      req_fire, op_legal, pay_fire, end_match, wd_expire;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign state_dbg = state;
   assign req_fire  = req_valid && req_ready;
   assign pay_fire  = pay_valid && cmd_ready;
   assign op_legal  = (req_op == OP_UPDATE_ALL) || (req_op == OP_SEARCH) || (req_op == OP_UPDATE_ONE);
   // Only the completion strobe belonging to the in-flight op class counts.
   assign end_match = (op_q == OP_UPDATE_ALL) ? update_all_end : search_end;

   always_comb begin
      cmd_beat_nxt       = '0;
      cmd_beat_nxt[31:0] = 32'(req_op);
      if (req_op == OP_UPDATE_ALL) cmd_beat_nxt[61:32] = req_count;
   end

`ifdef CAM_CMD_TIMEOUT_EN
   logic [31:0] wd_cnt;

   always_ff @(posedge clk) begin
      if (rst || state != WAIT_END) wd_cnt <= '0;
      else                          wd_cnt <= wd_cnt + 32'd1;
   end

   assign wd_expire = (state == WAIT_END) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
   logic [31:0] unused_timeout_limit;
   assign unused_timeout_limit = 32'(TIMEOUT_CYCLES);
   assign wd_expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_valid = 1'b0;
      cmd_data  = '0;
      pay_ready = 1'b0;
      done      = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: begin
            if (req_fire && op_legal) state_nxt = SEND_CMD;
         end
         SEND_CMD: begin
            cmd_valid = 1'b1;
            cmd_data  = cmd_beat;
            if (cmd_ready) state_nxt = (beats_left != '0) ? SEND_PAY : WAIT_END;
         end
         SEND_PAY: begin
            cmd_valid = pay_valid;
            cmd_data  = pay_data;
            pay_ready = cmd_ready;
            if (pay_fire && beats_left == 30'd1) state_nxt = WAIT_END;
         end
         WAIT_END: begin
            // A strobe in the limit cycle wins over the watchdog.
            if (end_seen || end_match) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (wd_expire) begin
               timeout   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q         <= '0;
         beats_left   <= '0;
         end_seen     <= 1'b0;
         cmd_beat     <= '0;
         err_illegal  <= 1'b0;
         cmd_done_cnt <= '0;
      end else begin
         err_illegal <= req_fire && !op_legal;
         if (state == IDLE && req_fire && op_legal) begin
            op_q       <= req_op;
            beats_left <= (req_op == OP_UPDATE_ALL) ? req_count : 30'd1;
            cmd_beat   <= cmd_beat_nxt;
         end
         if (state == SEND_PAY && pay_fire) beats_left <= beats_left - 30'd1;
         // Early completion is remembered until WAIT_END consumes it.
         if ((state == SEND_CMD || state == SEND_PAY) && end_match) end_seen <= 1'b1;
         else if (state == WAIT_END && state_nxt == IDLE)          end_seen <= 1'b0;
         if (done) cmd_done_cnt <= cmd_done_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_cam_cmd_issuer.sv
// Directed bench for cam_cmd_issuer: scoreboarded beat stream plus per-scenario checks.
module tb_cam_cmd_issuer;
   localparam int DW = 512;
   localparam logic [1:0] ST_IDLE = 2'd0, ST_SEND_PAY = 2'd2, ST_WAIT_END = 2'd3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [2:0]    req_op = '0;
   logic [29:0]   req_count = '0;
   logic [DW-1:0] pay_data = '0;
   logic          pay_valid = 1'b0;
   logic          pay_ready;
   logic [DW-1:0] cmd_data;
   logic          cmd_valid;
   logic          cmd_ready = 1'b1;
   logic          search_end = 1'b0;
   logic          update_all_end = 1'b0;
   logic          busy, done, err_illegal, timeout;
   logic [31:0]   cmd_done_cnt;
   logic [1:0]    state_dbg;

   logic [DW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_pass = 0;
   int            done_pulses = 0;
   logic          toggle_en = 1'b0;

   cam_cmd_issuer #(.C_DATA_WIDTH(DW), .OP_CODE_WIDTH(3), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_count(req_count), .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready),
      .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .search_end(search_end),
      .update_all_end(update_all_end), .busy(busy), .done(done), .err_illegal(err_illegal),
      .timeout(timeout), .cmd_done_cnt(cmd_done_cnt), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: got simulation time %0t required finish earlier", $time);
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // scoreboard: every valid beat must match the head of exp_q; pop on accept
   always @(negedge clk) begin
      if (done === 1'b1) done_pulses++;
      if (cmd_valid === 1'b1) begin
         check("beat_expected", DW'(exp_q.size() != 0), DW'(1));
         if (exp_q.size() != 0) begin
            check("beat_data", cmd_data, exp_q[0]);
            if (cmd_ready) void'(exp_q.pop_front());
         end
      end
   end

   always begin
      @(posedge clk);
      if (toggle_en) #1 cmd_ready = ~cmd_ready;
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [2:0] op, input logic [29:0] cnt);
      logic [DW-1:0] e;
      e = '0;
      e[31:0] = {29'd0, op};
      if (op == 3'd1) e[61:32] = cnt;
      exp_q.push_back(e);
   endtask

   task automatic send_req(input logic [2:0] op, input logic [29:0] cnt);
      logic ok;
      ok = 1'b0;
      req_valid = 1'b1;
      req_op    = op;
      req_count = cnt;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("req_accept", DW'(ok), DW'(1));
      tick();
      req_valid = 1'b0;
   endtask

   task automatic send_pay(input logic [DW-1:0] base, input int n);
      for (int b = 0; b < n; b++) begin
         logic ok;
         ok = 1'b0;
         pay_valid = 1'b1;
         pay_data  = base + DW'(b);
         exp_q.push_back(base + DW'(b));
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pay_ready) begin
               ok = 1'b1;
               break;
            end
         end
         check("pay_accept", DW'(ok), DW'(1));
         tick();
      end
      pay_valid = 1'b0;
   endtask

   task automatic wait_state(input logic [1:0] st, input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (state_dbg == st) begin
            ok = 1'b1;
            break;
         end
      end
      check(tag, DW'(ok), DW'(1));
   endtask

   logic [2:0] bad_ops [3];

   initial begin
      bad_ops = '{3'd0, 3'd5, 3'd7};
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", DW'(req_ready), DW'(1));
      check("rst_cmd_valid", DW'(cmd_valid), DW'(0));
      check("rst_cmd_data", cmd_data, DW'(0));
      check("rst_pay_ready", DW'(pay_ready), DW'(0));
      check("rst_busy", DW'(busy), DW'(0));
      check("rst_done", DW'(done), DW'(0));
      check("rst_err", DW'(err_illegal), DW'(0));
      check("rst_timeout", DW'(timeout), DW'(0));
      check("rst_cnt", DW'(cmd_done_cnt), DW'(0));

      // SEARCH, one key beat, completion five cycles into WAIT_END
      tick();
      push_cmd(3'd2, 30'd123);
      send_req(3'd2, 30'd123);
      send_pay(DW'(64'hA5A5_0000_1234_5678), 1);
      @(negedge clk);
      check("srch_wait_state", DW'(state_dbg), DW'(ST_WAIT_END));
      check("srch_wait_busy", DW'(busy), DW'(1));
      check("srch_wait_nodone", DW'(done), DW'(0));
      repeat (4) tick();
      search_end = 1'b1;
      @(negedge clk);
      check("srch_done", DW'(done), DW'(1));
      tick();
      search_end = 1'b0;
      @(negedge clk);
      check("srch_done_clr", DW'(done), DW'(0));
      check("srch_busy_clr", DW'(busy), DW'(0));
      check("srch_cnt", DW'(cmd_done_cnt), DW'(1));
      check("srch_beats_all", DW'(exp_q.size()), DW'(0));

      // UPDATE_ALL x4 with cmd_ready toggling; search_end must be ignored
      tick();
      toggle_en  = 1'b1;
      search_end = 1'b1;
      push_cmd(3'd1, 30'd4);
      send_req(3'd1, 30'd4);
      send_pay({DW{1'b1}} - DW'(100), 4);
      repeat (3) tick();
      @(negedge clk);
      check("ua_ignore_search", DW'(state_dbg), DW'(ST_WAIT_END));
      check("ua_ignore_done", DW'(done_pulses), DW'(1));
      toggle_en = 1'b0;
      tick();
      cmd_ready      = 1'b1;
      search_end     = 1'b0;
      update_all_end = 1'b1;
      @(negedge clk);
      check("ua_done", DW'(done), DW'(1));
      tick();
      update_all_end = 1'b0;
      @(negedge clk);
      check("ua_cnt", DW'(cmd_done_cnt), DW'(2));
      check("ua_beats_all", DW'(exp_q.size()), DW'(0));

      // UPDATE_ALL with zero payload beats
      tick();
      push_cmd(3'd1, 30'd0);
      send_req(3'd1, 30'd0);
      wait_state(ST_WAIT_END, "ua0_reach_wait");
      check("ua0_beats_all", DW'(exp_q.size()), DW'(0));
      check("ua0_pay_ready", DW'(pay_ready), DW'(0));
      tick();
      update_all_end = 1'b1;
      @(negedge clk);
      check("ua0_done", DW'(done), DW'(1));
      tick();
      update_all_end = 1'b0;
      @(negedge clk);
      check("ua0_cnt", DW'(cmd_done_cnt), DW'(3));

      // illegal opcodes
      foreach (bad_ops[k]) begin
         tick();
         req_valid = 1'b1;
         req_op    = bad_ops[k];
         @(negedge clk);
         check("ill_req_ready", DW'(req_ready), DW'(1));
         tick();
         req_valid = 1'b0;
         @(negedge clk);
         check("ill_err_pulse", DW'(err_illegal), DW'(1));
         check("ill_cmd_valid", DW'(cmd_valid), DW'(0));
         check("ill_busy", DW'(busy), DW'(0));
         check("ill_req_ready_after", DW'(req_ready), DW'(1));
         tick();
         @(negedge clk);
         check("ill_err_clr", DW'(err_illegal), DW'(0));
      end

      // UPDATE_ONE with search_end on the key accept cycle
      tick();
      cmd_ready = 1'b1;
      push_cmd(3'd3, 30'd777);
      exp_q.push_back(DW'(64'hC0FF_EE00_0000_0042));
      pay_valid = 1'b1;
      pay_data  = DW'(64'hC0FF_EE00_0000_0042);
      send_req(3'd3, 30'd777);
      tick();
      search_end = 1'b1;
      @(negedge clk);
      check("u1_in_pay", DW'(state_dbg), DW'(ST_SEND_PAY));
      check("u1_pay_ready", DW'(pay_ready), DW'(1));
      tick();
      search_end = 1'b0;
      pay_valid  = 1'b0;
      @(negedge clk);
      check("u1_early_done", DW'(done), DW'(1));
      tick();
      @(negedge clk);
      check("u1_done_clr", DW'(done), DW'(0));
      check("u1_cnt", DW'(cmd_done_cnt), DW'(4));
      check("u1_busy", DW'(busy), DW'(0));

      // reset in the middle of an UPDATE_ALL payload
      tick();
      push_cmd(3'd1, 30'd3);
      send_req(3'd1, 30'd3);
      tick();
      rst       = 1'b1;
      pay_valid = 1'b1;
      pay_data  = DW'(64'hDEAD_BEEF);
      exp_q.push_back(DW'(64'hDEAD_BEEF));
      @(negedge clk);
      check("rstmid_in_pay", DW'(state_dbg), DW'(ST_SEND_PAY));
      tick();
      @(negedge clk);
      check("rstmid_cmd_valid", DW'(cmd_valid), DW'(0));
      check("rstmid_busy", DW'(busy), DW'(0));
      check("rstmid_req_ready", DW'(req_ready), DW'(1));
      check("rstmid_cnt", DW'(cmd_done_cnt), DW'(0));
      tick();
      rst       = 1'b0;
      pay_valid = 1'b0;
      @(negedge clk);
      check("rstmid_beats_all", DW'(exp_q.size()), DW'(0));

      // recovery after reset
      tick();
      push_cmd(3'd2, 30'd0);
      send_req(3'd2, 30'd0);
      send_pay(DW'(64'h1111_2222), 1);
      search_end = 1'b1;
      @(negedge clk);
      check("rec_done", DW'(done), DW'(1));
      tick();
      search_end = 1'b0;
      @(negedge clk);
      check("rec_cnt", DW'(cmd_done_cnt), DW'(1));
      check("rec_idle", DW'(state_dbg), DW'(ST_IDLE));

`ifdef CAM_CMD_TIMEOUT_EN
      begin
         int fire_at;
         int n_to;
         fire_at = 0;
         n_to    = 0;
         tick();
         push_cmd(3'd2, 30'd0);
         send_req(3'd2, 30'd0);
         send_pay(DW'(64'h3333), 1);
         for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (timeout) begin
               n_to++;
               fire_at = c;
            end
         end
         check("to_cycle", DW'(fire_at), DW'(16));
         check("to_once", DW'(n_to), DW'(1));
         check("to_no_done", DW'(done_pulses), DW'(5));
         check("to_cnt", DW'(cmd_done_cnt), DW'(1));
         check("to_idle", DW'(state_dbg), DW'(ST_IDLE));
         tick();
         push_cmd(3'd2, 30'd0);
         send_req(3'd2, 30'd0);
         send_pay(DW'(64'h4444), 1);
         search_end = 1'b1;
         @(negedge clk);
         check("to_next_done", DW'(done), DW'(1));
         tick();
         search_end = 1'b0;
         @(negedge clk);
         check("to_next_cnt", DW'(cmd_done_cnt), DW'(2));
      end
`endif

      tick();
      @(negedge clk);
`ifdef CAM_CMD_TIMEOUT_EN
      check("total_done_pulses", DW'(done_pulses), DW'(6));
`else
      check("total_done_pulses", DW'(done_pulses), DW'(5));
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
